// File: rtl/cnn_udiv_11ns_7ns_11_seq.sv
// Sequential restoring unsigned divider: one quotient bit per enabled clock, start/done handshake.
// Optional macro CNN_UDIV_DBZ_FAST_EN: a zero divisor skips the iterative steps and finishes next cycle.
module cnn_udiv_11ns_7ns_11_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state
);

  localparam int N  = din0_WIDTH;
  localparam int M  = din1_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is sampled only in IDLE on a ce=1 edge; done is high for the
  // single DONE state and quot/rem/div_by_zero are valid from then until the next accept.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [N-1:0]    q_reg;
  logic [M-1:0]    d_reg;
  logic [M-1:0]    r_reg;
  logic [CW-1:0]   cnt;

  logic [M:0]      t_val;
  logic            ge;
  logic [M-1:0]    step_r;
  logic [N-1:0]    step_q;
  logic            last_step;

  // One restoring step. When t >= d the true difference is below d, so its low M bits
  // are exact; with d==0 every bit is 1 and the remainder simply shifts the dividend in.
  always_comb begin
    t_val     = {r_reg, q_reg[N-1]};
    ge        = (t_val >= {1'b0, d_reg});
    step_r    = ge ? (t_val[M-1:0] - d_reg) : t_val[M-1:0];
    step_q    = {q_reg[N-2:0], ge};
    last_step = (cnt == CW'(N - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef CNN_UDIV_DBZ_FAST_EN
          next_state = (din1 == '0) ? DONE : CALC;
`else
          next_state = CALC;
`endif
        end
      end
      CALC:    if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg       <= din0;
            d_reg       <= din1;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= (din1 == '0);
`ifdef CNN_UDIV_DBZ_FAST_EN
            if (din1 == '0) begin
              quot <= '1;
              rem  <= din0[M-1:0];
            end
`endif
          end
        end
        CALC: begin
          q_reg <= step_q;
          r_reg <= step_r;
          cnt   <= cnt + CW'(1);
          // Result registers update on the final step so they are valid throughout DONE.
          if (last_step) begin
            quot <= step_q;
            rem  <= step_r;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cnn_udiv_11ns_7ns_11_seq.sv
// Directed bench for the sequential divider: latency, results, ce stalls, async reset, regression.
module tb_cnn_udiv_11ns_7ns_11_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [10:0] din0 = '0;
  logic [6:0]  din1 = '0;
  logic        busy, done, div_by_zero;
  logic [10:0] quot;
  logic [6:0]  rem;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;

`ifdef CNN_UDIV_DBZ_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 12;
`endif

  cnn_udiv_11ns_7ns_11_seq #(
    .ID(1), .din0_WIDTH(11), .din1_WIDTH(7), .dout_WIDTH(11)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [10:0] a, input logic [6:0] b);
    @(negedge ap_clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge ap_clk);
    #1 start = 1'b0;
    lat = 0;
  endtask

  task automatic wait_done(input string tag, input int max);
    while (lat < max) begin
      @(negedge ap_clk);
      lat++;
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input logic [10:0] a, input logic [6:0] b,
                     input logic [10:0] eq, input logic [6:0] er, input logic edbz,
                     input int elat);
    do_start(a, b);
    wait_done(tag, 40);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_quot"}, 32'(quot), 32'(eq));
    check({tag, "_rem"}, 32'(rem), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  initial begin
    logic [10:0] ra;
    logic [6:0]  rb;
    logic [10:0] rq;
    logic [6:0]  rr;

    // Reset state
    repeat (2) @(negedge ap_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    ap_rst_n = 1'b1;

    // 100/7 with cycle-exact done and busy
    do_start(11'd100, 7'd7);
    for (int i = 1; i <= 12; i++) begin
      @(negedge ap_clk);
      check("lat100_done", 32'(done), 32'(i == 12));
      check("lat100_busy", 32'(busy), 32'd1);
    end
    check("d100_quot", 32'(quot), 32'd14);
    check("d100_rem", 32'(rem), 32'd2);
    check("d100_dbz", 32'(div_by_zero), 32'd0);

    // start during DONE must be dropped
    start = 1'b1; din0 = 11'd50; din1 = 7'd5;
    @(posedge ap_clk);
    #1 start = 1'b0;
    @(negedge ap_clk);
    check("done_start_busy", 32'(busy), 32'd0);
    check("done_start_done", 32'(done), 32'd0);
    check("hold_quot", 32'(quot), 32'd14);
    check("hold_rem", 32'(rem), 32'd2);

    // Directed vectors, each start issued the cycle after the previous done
    run("d2047", 11'd2047, 7'd127, 11'd16, 7'd15, 1'b0, 12);
    run("d5_9", 11'd5, 7'd9, 11'd0, 7'd5, 1'b0, 12);
    run("d0_1", 11'd0, 7'd1, 11'd0, 7'd0, 1'b0, 12);
    run("dbz", 11'd5, 7'd0, 11'd2047, 7'd5, 1'b1, DBZ_LAT);
    run("after_dbz", 11'd100, 7'd7, 11'd14, 7'd2, 1'b0, 12);

    // ce stall mid-CALC plus an ignored start while busy
    do_start(11'd100, 7'd7);
    repeat (4) begin @(negedge ap_clk); lat++; end
    start = 1'b1; din0 = 11'd50; din1 = 7'd5;
    @(negedge ap_clk); lat++;
    start = 1'b0;
    ce = 1'b0;
    repeat (3) begin
      @(negedge ap_clk); lat++;
      check("stall_done", 32'(done), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    ce = 1'b1;
    wait_done("stall", 40);
    check("stall_lat", 32'(lat), 32'd15);
    check("stall_quot", 32'(quot), 32'd14);
    check("stall_rem", 32'(rem), 32'd2);

    // done holds while stalled in DONE
    ce = 1'b0;
    repeat (2) begin
      @(negedge ap_clk);
      check("done_stall", 32'(done), 32'd1);
    end
    ce = 1'b1;
    @(negedge ap_clk);
    check("done_release", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a division
    do_start(11'd100, 7'd7);
    repeat (5) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quot", 32'(quot), 32'd0);
    check("arst_rem", 32'(rem), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run("d63_8", 11'd63, 7'd8, 11'd7, 7'd7, 1'b0, 12);

    // Random back-to-back regression against the division identity
    for (int n = 0; n < 300; n++) begin
      ra = 11'($urandom_range(0, 2047));
      rb = 7'($urandom_range(1, 127));
      rq = ra / 11'(rb);
      rr = 7'(ra % 11'(rb));
      run("rnd", ra, rb, rq, rr, 1'b0, 12);
      check("rnd_ident", 32'(quot) * 32'(rb) + 32'(rem), 32'(ra));
      check("rnd_rem_lt", 32'(rem < rb), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
